// File: rtl/systolic_pkg.sv
// Shared dimensions and feeder state encoding for the systolic datapath
// (register file, skew feeder and PE array all import the same N/DW).
package systolic_pkg;
    localparam int N      = 8;
    localparam int DW     = 16;
    localparam int BEAT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE_S
    } feeder_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying one lane's data with its valid bit.
// Shifts every cycle; no stall input because the array never backpressures.
module skew_delay_line #(
    parameter int DW    = 16,
    parameter int DEPTH = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_VALID
);
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
        data_d[0] = IN_DATA;
        vld_d[0]  = IN_VALID;
        for (int s = 1; s < DEPTH; s++) begin
            data_d[s] = data_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

    // Data is cleared on reset too so a flushed lane shows zeros, not stale beats.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign OUT_DATA  = data_q[DEPTH-1];
    assign OUT_VALID = vld_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: lane i delays its beat by i+1 registers so the PE array
// sees a wavefront; after the last beat it drains, pulses DONE and holds the beat count.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            IN_VALID,
    input  logic                            IN_LAST,
    output logic                            IN_READY,
    input  logic [DW-1:0]                   R_IN [0:N-1],
    input  logic [DW-1:0]                   C_IN [0:N-1],
    output logic [DW-1:0]                   A_OUT [0:N-1],
    output logic [DW-1:0]                   B_OUT [0:N-1],
    output logic [N-1:0]                    LANE_VALID,
    output logic                            BUSY,
    output logic                            DONE,
    output logic [systolic_pkg::BEAT_W-1:0] BEAT_COUNT
);
    // Drain counter only has to reach N-2.
    localparam int            CW         = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2);

    feeder_state_t     state_q, state_d;
    logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              accept;
    logic [DW-1:0]     a_entry [N];
    logic [DW-1:0]     b_entry [N];
    logic [N-1:0]      a_vld;
    logic [N-1:0]      b_vld;

    assign IN_READY   = (state_q == IDLE) || (state_q == STREAM);
    assign accept     = IN_VALID && IN_READY;
    assign BUSY       = (state_q != IDLE);
    assign DONE       = (state_q == DONE_S);
    assign BEAT_COUNT = beat_cnt_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    beat_cnt_d  = BEAT_W'(1);
                    drain_cnt_d = '0;
                    state_d     = IN_LAST ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (IN_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE_S;
                end
            end
            DONE_S:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Lane entry: an accepted beat enters, anything else enters as a zero bubble.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_entry[i] = accept ? R_IN[i] : '0;
            b_entry[i] = accept ? C_IN[i] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DW   (DW),
            .DEPTH(i + 1)
        ) u_row (
            .CLK      (CLK),
            .RST      (RST),
            .IN_DATA  (a_entry[i]),
            .IN_VALID (accept),
            .OUT_DATA (A_OUT[i]),
            .OUT_VALID(a_vld[i])
        );
        skew_delay_line #(
            .DW   (DW),
            .DEPTH(i + 1)
        ) u_col (
            .CLK      (CLK),
            .RST      (RST),
            .IN_DATA  (b_entry[i]),
            .IN_VALID (accept),
            .OUT_DATA (B_OUT[i]),
            .OUT_VALID(b_vld[i])
        );
    end

    // Row and column valid paths are identical; requiring both keeps each in use.
    assign LANE_VALID = a_vld & b_vld;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a per-edge behavioural model
// built from the timing rules, plus scenario tasks with direct constant checks.
module tb_systolic_skew_feeder;
    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int RING = 64;
    localparam int OW   = 2 * N * DW + N + 3 + 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_LAST;
    logic          IN_READY;
    logic [DW-1:0] R_IN  [0:N-1];
    logic [DW-1:0] C_IN  [0:N-1];
    logic [DW-1:0] A_OUT [0:N-1];
    logic [DW-1:0] B_OUT [0:N-1];
    logic [N-1:0]  LANE_VALID;
    logic          BUSY;
    logic          DONE;
    logic [15:0]   BEAT_COUNT;

    int passed = 0;
    int total  = 0;

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_LAST   (IN_LAST),
        .IN_READY  (IN_READY),
        .R_IN      (R_IN),
        .C_IN      (C_IN),
        .A_OUT     (A_OUT),
        .B_OUT     (B_OUT),
        .LANE_VALID(LANE_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BEAT_COUNT(BEAT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Observed outputs packed into one vector for whole-state comparison.
    logic [N*DW-1:0] a_flat, b_flat;
    logic [OW-1:0]   obs;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_flat[i*DW +: DW] = A_OUT[i];
            b_flat[i*DW +: DW] = B_OUT[i];
        end
        obs = {a_flat, b_flat, LANE_VALID, BUSY, DONE, IN_READY, BEAT_COUNT};
    end

    // Reference model: a beat accepted at edge e appears on lane i after edge e+i;
    // the last beat at edge k blocks input after edges k..k+N-1 and DONE follows edge k+N-1.
    int              cyc      = 0;
    int              rst_edge = -1;
    int              last_k   = -1000;
    bit              in_op    = 1'b0;
    logic [15:0]     m_cnt    = '0;
    bit              acc [RING];
    logic [DW-1:0]   rh  [RING][N];
    logic [DW-1:0]   ch  [RING][N];
    logic [N*DW-1:0] ea, eb;
    logic [N-1:0]    ev;
    logic [OW-1:0]   exp_obs;
    logic [OW-1:0]   reset_obs;

    always @(posedge CLK) begin
        int  e;
        int  src;
        bit  ready;
        bit  m_busy;
        bit  m_done;
        e     = cyc;
        ready = !((e - 1) >= last_k && (e - 1) <= last_k + N - 1);
        acc[e % RING] = 1'b0;
        if (RST) begin
            rst_edge = e;
            last_k   = -1000;
            in_op    = 1'b0;
            m_cnt    = '0;
        end else if (IN_VALID && ready) begin
            acc[e % RING] = 1'b1;
            for (int i = 0; i < N; i++) begin
                rh[e % RING][i] = R_IN[i];
                ch[e % RING][i] = C_IN[i];
            end
            if (!in_op) begin
                m_cnt = 16'd1;
                in_op = 1'b1;
            end else if (m_cnt != 16'hFFFF) begin
                m_cnt = m_cnt + 16'd1;
            end
            if (IN_LAST) begin
                last_k = e;
                in_op  = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            src = e - i;
            if (src >= 0 && src > rst_edge && acc[src % RING]) begin
                ea[i*DW +: DW] = rh[src % RING][i];
                eb[i*DW +: DW] = ch[src % RING][i];
                ev[i]          = 1'b1;
            end else begin
                ea[i*DW +: DW] = '0;
                eb[i*DW +: DW] = '0;
                ev[i]          = 1'b0;
            end
        end
        m_busy  = in_op || (e >= last_k && e <= last_k + N - 1);
        m_done  = (e == last_k + N - 1);
        exp_obs = {ea, eb, ev, m_busy, m_done, !(e >= last_k && e <= last_k + N - 1), m_cnt};
        cyc     = e + 1;
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_idle();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        for (int i = 0; i < N; i++) begin
            R_IN[i] = '0;
            C_IN[i] = '0;
        end
    endtask

    // Random payload with bit 15 clear so it can never look like 16'hDEAD.
    task automatic set_rand_beat(input bit last);
        IN_VALID = 1'b1;
        IN_LAST  = last;
        for (int i = 0; i < N; i++) begin
            R_IN[i] = DW'($urandom) & 16'h7FFF;
            C_IN[i] = DW'($urandom) & 16'h7FFF;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_rand_beat(1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs !== reset_obs) $display("FAIL reset_values c=%0d got=%h want=%h", c, obs, reset_obs);
            else passed++;
        end
        RST = 1'b0;
        set_idle();
    endtask

    task automatic test_single();
        int k, dones, done_at;
        logic [N-1:0] oh;
        dones = 0; done_at = -1;
        IN_VALID = 1'b1;
        IN_LAST  = 1'b1;
        for (int i = 0; i < N; i++) begin
            R_IN[i] = DW'(16'h0100 + i);
            C_IN[i] = DW'(16'h0200 + i);
        end
        for (int c = 0; c < N + 2; c++) begin
            tick();
            if (c == 0) begin
                k = cyc - 1;
                set_idle();
            end
            total++;
            if (obs !== exp_obs) $display("FAIL single_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            if (c < N) begin
                oh = '0; oh[c] = 1'b1;
                total++;
                if (A_OUT[c] !== DW'(16'h0100 + c) || B_OUT[c] !== DW'(16'h0200 + c) || LANE_VALID !== oh)
                    $display("FAIL single_lane%0d got a=%h b=%h v=%b want a=%h b=%h v=%b", c, A_OUT[c], B_OUT[c],
                             LANE_VALID, DW'(16'h0100 + c), DW'(16'h0200 + c), oh);
                else passed++;
            end
            if (DONE) begin dones++; done_at = cyc - 1; end
        end
        total++;
        if (dones !== 1 || done_at !== k + N - 1 || BEAT_COUNT !== 16'd1)
            $display("FAIL single_done got dones=%0d at=%0d cnt=%0d want 1 at=%0d cnt=1", dones, done_at, BEAT_COUNT, k + N - 1);
        else passed++;
    endtask

    task automatic test_eight_beats();
        int k0, dones, not_ready, first3;
        logic [DW-1:0] lane3 [$];
        dones = 0; not_ready = 0; first3 = -1;
        for (int c = 0; c < 8 + N + 1; c++) begin
            if (c < 8) begin
                IN_VALID = 1'b1;
                IN_LAST  = (c == 7);
                for (int i = 0; i < N; i++) begin
                    R_IN[i] = DW'(c + 1);
                    C_IN[i] = DW'(c + 1);
                end
            end else set_idle();
            tick();
            if (c == 0) k0 = cyc - 1;
            total++;
            if (obs !== exp_obs) $display("FAIL eight_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            if (!IN_READY) not_ready++;
            if (DONE) dones++;
            if (LANE_VALID[3]) begin
                if (first3 < 0) first3 = cyc - 1;
                lane3.push_back(A_OUT[3]);
            end
        end
        total++;
        if (lane3.size() !== 8 || first3 !== k0 + 3)
            $display("FAIL eight_lane3_timing got n=%0d first=%0d want n=8 first=%0d", lane3.size(), first3, k0 + 3);
        else passed++;
        for (int j = 0; j < lane3.size(); j++) begin
            total++;
            if (lane3[j] !== DW'(j + 1)) $display("FAIL eight_lane3_val j=%0d got=%h want=%h", j, lane3[j], DW'(j + 1));
            else passed++;
        end
        total++;
        if (not_ready !== 8 || dones !== 1 || BEAT_COUNT !== 16'd8)
            $display("FAIL eight_summary got nready=%0d dones=%0d cnt=%0d want 8 1 8", not_ready, dones, BEAT_COUNT);
        else passed++;
    endtask

    task automatic test_bubbles();
        int lane5_hits;
        lane5_hits = 0;
        for (int c = 0; c < 5 + N + 1; c++) begin
            if (c < 5 && (c % 2) == 0) set_rand_beat(c == 4);
            else set_idle();
            tick();
            total++;
            if (obs !== exp_obs) $display("FAIL bubbles_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            if (LANE_VALID[5]) lane5_hits++;
        end
        total++;
        if (BEAT_COUNT !== 16'd3 || lane5_hits !== 3)
            $display("FAIL bubbles_count got cnt=%0d hits=%0d want 3 3", BEAT_COUNT, lane5_hits);
        else passed++;
    endtask

    task automatic test_ignored();
        int dead_seen;
        dead_seen = 0;
        set_rand_beat(1'b1);
        for (int c = 0; c < N + 3; c++) begin
            tick();
            if (!IN_READY) begin
                IN_VALID = 1'b1;
                IN_LAST  = 1'b0;
                for (int i = 0; i < N; i++) begin
                    R_IN[i] = 16'hDEAD;
                    C_IN[i] = 16'hDEAD;
                end
            end else set_idle();
            total++;
            if (obs !== exp_obs) $display("FAIL ignored_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            for (int i = 0; i < N; i++)
                if (A_OUT[i] === 16'hDEAD || B_OUT[i] === 16'hDEAD) dead_seen++;
        end
        set_idle();
        total++;
        if (dead_seen !== 0 || BEAT_COUNT !== 16'd1)
            $display("FAIL ignored_input got dead=%0d cnt=%0d want 0 1", dead_seen, BEAT_COUNT);
        else passed++;
    endtask

    task automatic test_reset_mid_drain();
        int dones;
        dones = 0;
        set_rand_beat(1'b0);
        tick();
        set_rand_beat(1'b1);
        tick();
        set_idle();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if (obs !== reset_obs) $display("FAIL mid_drain_reset got=%h want=%h", obs, reset_obs);
        else passed++;
        for (int c = 0; c < N + 2; c++) begin
            total++;
            if (obs !== exp_obs) $display("FAIL mid_drain_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            if (DONE) dones++;
            tick();
        end
        total++;
        if (dones !== 0) $display("FAIL mid_drain_done got=%0d want=0", dones);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        bit sent;
        d1 = -1; d2 = -1; sent = 1'b0;
        set_rand_beat(1'b1);
        tick();
        set_idle();
        for (int c = 0; c < 4 * N && d2 < 0; c++) begin
            if (IN_READY && !sent) begin
                set_rand_beat(1'b1);
                sent = 1'b1;
            end
            tick();
            set_idle();
            total++;
            if (obs !== exp_obs) $display("FAIL b2b_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
            if (DONE) begin
                total++;
                if (BEAT_COUNT !== 16'd1) $display("FAIL b2b_count got=%0d want=1", BEAT_COUNT);
                else passed++;
                if (d1 < 0) d1 = cyc - 1;
                else d2 = cyc - 1;
            end
        end
        total++;
        if (d1 < 0 || d2 < 0 || d2 - d1 !== N + 1)
            $display("FAIL b2b_spacing got d1=%0d d2=%0d want gap=%0d", d1, d2, N + 1);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300 + N + 2; c++) begin
            if (c < 300) begin
                RST = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 9) < 7) set_rand_beat($urandom_range(0, 5) == 0);
                else set_idle();
            end else begin
                RST = 1'b0;
                set_idle();
            end
            tick();
            total++;
            if (obs !== exp_obs) $display("FAIL random_model c=%0d got=%h want=%h", c, obs, exp_obs);
            else passed++;
        end
    endtask

    initial begin
        reset_obs     = '0;
        reset_obs[16] = 1'b1;
        RST = 1'b1;
        set_idle();
        test_reset();
        test_single();
        tick();
        test_eight_beats();
        tick();
        test_bubbles();
        tick();
        test_ignored();
        tick();
        test_reset_mid_drain();
        test_back_to_back();
        tick();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
